// File: rtl/extrema_scheduler.sv
// Sweeps the shared check_extrema engine over every DoG octave and queues keypoints.
module extrema_scheduler #(
    parameter int unsigned NUM_OCTAVES = 3,
    parameter int unsigned BIT_DEPTH   = 9,
    parameter int unsigned DIMENSION   = 4,
    parameter int unsigned FIFO_DEPTH  = 8,
    localparam int unsigned ADDR_W = $clog2(DIMENSION * DIMENSION),
    localparam int unsigned XY_W   = $clog2(DIMENSION),
    localparam int unsigned OCT_W  = (NUM_OCTAVES > 1) ? $clog2(NUM_OCTAVES) : 1,
    localparam int unsigned DATA_W = NUM_OCTAVES * BIT_DEPTH
) (
    input  logic                        clk,
    input  logic                        rst_in,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic                        overflow,
    output logic                        chk_enable,
    input  logic                        chk_first_is_extremum,
    input  logic                        chk_second_is_extremum,
    input  logic [XY_W-1:0]             chk_x,
    input  logic [XY_W-1:0]             chk_y,
    input  logic                        chk_done_checking,
    input  logic [ADDR_W-1:0]           chk_first_address,
    input  logic [ADDR_W-1:0]           chk_second_address,
    output logic signed [BIT_DEPTH-1:0] chk_first_data,
    output logic signed [BIT_DEPTH-1:0] chk_second_data,
    output logic [ADDR_W-1:0]           bram_first_address,
    output logic [ADDR_W-1:0]           bram_second_address,
    input  logic [DATA_W-1:0]           bram_first_data,
    input  logic [DATA_W-1:0]           bram_second_data,
    output logic                        kp_valid,
    input  logic                        kp_ready,
    output logic [XY_W-1:0]             kp_x,
    output logic [XY_W-1:0]             kp_y,
    output logic [OCT_W-1:0]            kp_octave,
    output logic                        kp_layer
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [XY_W-1:0]  x;
        logic [XY_W-1:0]  y;
        logic [OCT_W-1:0] oct;
        logic             layer;
    } kp_t;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_CHK,
        NEXT,
        DRAIN
    } state_t;

    state_t           state, state_nxt;
    logic [OCT_W-1:0] octave, octave_nxt;
    logic             busy_nxt, done_nxt, chk_enable_nxt, start_acc, overflow_nxt;

    kp_t              mem [FIFO_DEPTH];
    kp_t              head;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count, count_nxt;
    logic             full, fifo_empty, push_req, push_ok, pop;

    kp_t              push_entry, pend_entry;
    logic             pend_valid, pend_set, pend_clr;

    // Address broadcast and octave-steered read data back to the checker
    assign bram_first_address  = chk_first_address;
    assign bram_second_address = chk_second_address;
    assign chk_first_data      = bram_first_data[BIT_DEPTH * 32'(octave) +: BIT_DEPTH];
    assign chk_second_data     = bram_second_data[BIT_DEPTH * 32'(octave) +: BIT_DEPTH];

    // Event capture: layer 0 wins a same-cycle tie, layer 1 waits one cycle in pending
    always_comb begin
        push_req   = 1'b0;
        push_entry = pend_entry;
        pend_set   = 1'b0;
        pend_clr   = 1'b0;
        if (chk_first_is_extremum) begin
            push_req   = 1'b1;
            push_entry = '{x: chk_x, y: chk_y, oct: octave, layer: 1'b0};
            pend_set   = chk_second_is_extremum;
        end else if (chk_second_is_extremum) begin
            push_req   = 1'b1;
            push_entry = '{x: chk_x, y: chk_y, oct: octave, layer: 1'b1};
        end else if (pend_valid) begin
            push_req   = 1'b1;
            pend_clr   = 1'b1;
        end
    end

    // FIFO bookkeeping: a full FIFO still accepts a push when it is popped the same cycle
    always_comb begin
        full       = (count == CNT_W'(FIFO_DEPTH));
        fifo_empty = (count == '0);
        pop        = kp_valid && kp_ready;
        push_ok    = push_req && (!full || pop);
        count_nxt  = count + CNT_W'(push_ok) - CNT_W'(pop);
    end

    // Sweep sequencer next-state and registered-output values
    always_comb begin
        state_nxt      = state;
        octave_nxt     = octave;
        busy_nxt       = busy;
        done_nxt       = 1'b0;
        chk_enable_nxt = 1'b0;
        start_acc      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    start_acc  = 1'b1;
                    octave_nxt = '0;
                    busy_nxt   = 1'b1;
                    state_nxt  = LAUNCH;
                end
            end
            LAUNCH: begin
                chk_enable_nxt = 1'b1;
                state_nxt      = WAIT_CHK;
            end
            WAIT_CHK: begin
                if (chk_done_checking) begin
                    state_nxt = NEXT;
                end
            end
            NEXT: begin
                if (octave == OCT_W'(NUM_OCTAVES - 1)) begin
                    state_nxt = DRAIN;
                end else begin
                    octave_nxt = octave + 1'b1;
                    state_nxt  = LAUNCH;
                end
            end
            DRAIN: begin
                if (fifo_empty && !pend_valid && !push_req) begin
                    done_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Sticky drop flag, cleared only by an accepted start
    always_comb begin
        overflow_nxt = overflow;
        if (start_acc) begin
            overflow_nxt = 1'b0;
        end
        if (push_req && !push_ok) begin
            overflow_nxt = 1'b1;
        end
    end

    // Control state, FIFO pointers and pending entry
    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            state      <= IDLE;
            octave     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            chk_enable <= 1'b0;
            overflow   <= 1'b0;
            kp_valid   <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            pend_valid <= 1'b0;
            pend_entry <= '0;
        end else begin
            state      <= state_nxt;
            octave     <= octave_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            chk_enable <= chk_enable_nxt;
            overflow   <= overflow_nxt;
            count      <= count_nxt;
            kp_valid   <= (count_nxt != '0);
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            pend_valid <= pend_set | (pend_valid & ~pend_clr);
            if (pend_set) begin
                pend_entry <= '{x: chk_x, y: chk_y, oct: octave, layer: 1'b1};
            end
        end
    end

    // Keypoint storage
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    assign head      = mem[rd_ptr];
    assign kp_x      = head.x;
    assign kp_y      = head.y;
    assign kp_octave = head.oct;
    assign kp_layer  = head.layer;

endmodule
